// File: rtl/shift_wb_buffer.sv
// rtl/shift_wb_buffer.sv - shift-unit writeback buffer: rd alignment, result FIFO, credit.
// Optional same-cycle bypass when SHIFT_WB_BYPASS_EN is defined.
module shift_wb_buffer #(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_flush,
  input  logic          i_issue_valid,
  input  logic [AW-1:0] i_issue_rd,
  output logic          o_issue_ready,
  input  logic [DW-1:0] i_shift_result,
  output logic          o_wb_valid,
  output logic [AW-1:0] o_wb_rd,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_ready,
  output logic          o_busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = AW + DW;

  logic          pend_valid_q, pend_valid_d;
  logic [AW-1:0] pend_rd_q, pend_rd_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];

  logic [CW:0]   inflight;
  logic          fifo_valid;
  logic [EW-1:0] fifo_head;
  logic          byp_cond;
  logic          bypass_taken;
  logic          acc;
  logic          push;
  logic          pop;

  // Credit counts the in-flight shifter op so its result always has a slot.
  assign inflight      = {1'b0, occ_q} + {{CW{1'b0}}, pend_valid_q};
  assign o_issue_ready = (inflight < (CW+1)'(DEPTH));
  assign acc           = i_issue_valid & o_issue_ready & ~i_flush;

  assign fifo_valid = (occ_q != '0);
  assign fifo_head  = mem_q[rd_ptr_q];

`ifdef SHIFT_WB_BYPASS_EN
  assign byp_cond = ~fifo_valid & pend_valid_q & (pend_rd_q != '0) & ~i_flush;
`else
  assign byp_cond = 1'b0;
`endif

  assign bypass_taken = byp_cond & i_wb_ready;

  always_comb begin
    o_wb_valid = fifo_valid | byp_cond;
    o_wb_rd    = fifo_head[EW-1:DW];
    o_wb_data  = fifo_head[DW-1:0];
    if (byp_cond) begin
      o_wb_rd   = pend_rd_q;
      o_wb_data = i_shift_result;
    end
  end

  assign pop    = o_wb_valid & i_wb_ready & fifo_valid;
  assign push   = pend_valid_q & (pend_rd_q != '0) & ~i_flush & ~bypass_taken;
  assign o_busy = pend_valid_q | fifo_valid;

  always_comb begin
    pend_valid_d = acc;
    pend_rd_d    = acc ? i_issue_rd : pend_rd_q;
    occ_d        = occ_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    mem_d        = mem_q;
    if (i_flush) begin
      occ_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {pend_rd_q, i_shift_result};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      occ_d = occ_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pend_valid_q <= 1'b0;
      pend_rd_q    <= '0;
      occ_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
      occ_q        <= occ_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_shift_wb_buffer.sv
// tb/tb_shift_wb_buffer.sv - randomized and directed bench for shift_wb_buffer against a queue model.
module tb_shift_wb_buffer;

  localparam int DEPTH = 2;
  localparam int DW    = 32;
  localparam int AW    = 5;
`ifdef SHIFT_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rstn;
  logic          i_flush;
  logic          i_issue_valid;
  logic [AW-1:0] i_issue_rd;
  logic          o_issue_ready;
  logic [DW-1:0] i_shift_result;
  logic          o_wb_valid;
  logic [AW-1:0] o_wb_rd;
  logic [DW-1:0] o_wb_data;
  logic          i_wb_ready;
  logic          o_busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] q_rd[$];
  logic [DW-1:0] q_data[$];
  bit            m_pend;
  logic [AW-1:0] m_pend_rd;
  bit            m_byp;
  bit            m_ready;

  shift_wb_buffer #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_flush       (i_flush),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .o_issue_ready (o_issue_ready),
    .i_shift_result(i_shift_result),
    .o_wb_valid    (o_wb_valid),
    .o_wb_rd       (o_wb_rd),
    .o_wb_data     (o_wb_data),
    .i_wb_ready    (i_wb_ready),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q_rd.delete();
    q_data.delete();
    m_pend    = 1'b0;
    m_pend_rd = '0;
  endtask

  // Compare the DUT against the model for the inputs currently applied.
  task automatic check_model();
    int occ;
    #1;
    occ     = q_rd.size();
    m_ready = (occ + int'(m_pend)) < DEPTH;
    m_byp   = BYP && occ == 0 && m_pend && m_pend_rd != 0 && !i_flush;
    chk("issue_ready", o_issue_ready, m_ready);
    chk("busy", o_busy, m_pend || occ != 0);
    chk("wb_valid", o_wb_valid, occ != 0 || m_byp);
    if (occ != 0) begin
      chk("wb_rd", o_wb_rd, q_rd[0]);
      chk("wb_data", o_wb_data, q_data[0]);
    end else if (m_byp) begin
      chk("byp_rd", o_wb_rd, m_pend_rd);
      chk("byp_data", o_wb_data, i_shift_result);
    end
  endtask

  task automatic advance();
    bit pop, btaken, acc;
    pop    = i_wb_ready && q_rd.size() > 0;
    btaken = m_byp && i_wb_ready;
    acc    = i_issue_valid && m_ready && !i_flush;
    if (i_flush) begin
      q_rd.delete();
      q_data.delete();
    end else begin
      if (pop) begin
        void'(q_rd.pop_front());
        void'(q_data.pop_front());
      end
      if (m_pend && m_pend_rd != 0 && !btaken) begin
        q_rd.push_back(m_pend_rd);
        q_data.push_back(i_shift_result);
      end
    end
    if (q_rd.size() > DEPTH) chk("no_push_when_full", q_rd.size(), DEPTH);
    m_pend = acc;
    if (acc) m_pend_rd = i_issue_rd;
    @(posedge i_clk);
    #1;
  endtask

  task automatic step();
    check_model();
    advance();
  endtask

  task automatic drive(input bit v, input logic [AW-1:0] rd, input logic [DW-1:0] res,
                       input bit rdy, input bit fl);
    i_issue_valid  = v;
    i_issue_rd     = rd;
    i_shift_result = res;
    i_wb_ready     = rdy;
    i_flush        = fl;
  endtask

  task automatic do_reset();
    i_rstn = 1'b0;
    #1;
    chk("rst_async_valid", o_wb_valid, 1'b0);
    chk("rst_async_busy", o_busy, 1'b0);
    chk("rst_async_ready", o_issue_ready, 1'b1);
    model_clear();
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] r;
    i_rstn = 1'b1;
    drive(0, '0, '0, 0, 0);
    model_clear();
    #1;
    i_rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive($urandom_range(0, 1), AW'($urandom), $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
      @(posedge i_clk);
      #1;
      chk("rst_valid", o_wb_valid, 1'b0);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_ready", o_issue_ready, 1'b1);
    end
    i_rstn = 1'b1;
    drive(0, '0, '0, 1, 0);
    check_model();
    chk("rst_wb_rd", o_wb_rd, '0);
    chk("rst_wb_data", o_wb_data, '0);
    advance();

    // single op, rd=5
    drive(1, 5'd5, '0, 1, 0);
    step();
    drive(0, '0, 32'h8000_0000, 1, 0);
    check_model();
`ifdef SHIFT_WB_BYPASS_EN
    chk("single_n1_valid", o_wb_valid, 1'b1);
    chk("single_n1_data", o_wb_data, 32'h8000_0000);
    advance();
    drive(0, '0, '0, 1, 0);
    check_model();
    chk("single_n2_valid", o_wb_valid, 1'b0);
`else
    chk("single_n1_valid", o_wb_valid, 1'b0);
    advance();
    drive(0, '0, '0, 1, 0);
    check_model();
    chk("single_n2_valid", o_wb_valid, 1'b1);
    chk("single_n2_rd", o_wb_rd, 5'd5);
    chk("single_n2_data", o_wb_data, 32'h8000_0000);
    advance();
    check_model();
    chk("single_n3_valid", o_wb_valid, 1'b0);
`endif
    advance();

    // backpressure: rd=1,2,3 with regfile stalled
    drive(1, 5'd1, $urandom, 0, 0);
    check_model();
    chk("bp_c0_ready", o_issue_ready, 1'b1);
    advance();
    drive(1, 5'd2, $urandom, 0, 0);
    check_model();
    chk("bp_c1_ready", o_issue_ready, 1'b1);
    advance();
    drive(1, 5'd3, $urandom, 0, 0);
    check_model();
    chk("bp_c2_ready", o_issue_ready, 1'b0);
    advance();
    drive(1, 5'd3, $urandom, 1, 0);
    check_model();
    chk("bp_c3_ready", o_issue_ready, 1'b0);
    chk("bp_c3_rd", o_wb_rd, 5'd1);
    advance();
    drive(1, 5'd3, $urandom, 1, 0);
    check_model();
    chk("bp_c4_ready", o_issue_ready, 1'b1);
    chk("bp_c4_rd", o_wb_rd, 5'd2);
    advance();
    for (int k = 0; k < 4; k++) begin
      drive(0, '0, $urandom, 1, 0);
      step();
    end

    // x0 discard
    drive(1, 5'd0, '0, 1, 0);
    step();
    drive(0, '0, 32'hFFFF_FFFF, 1, 0);
    check_model();
    chk("x0_n1_busy", o_busy, 1'b1);
    chk("x0_n1_valid", o_wb_valid, 1'b0);
    advance();
    check_model();
    chk("x0_n2_busy", o_busy, 1'b0);
    chk("x0_n2_valid", o_wb_valid, 1'b0);
    advance();

    // flush with one queued and one pending
    drive(1, 5'd9, $urandom, 0, 0);
    step();
    drive(1, 5'd10, $urandom, 0, 0);
    step();
    drive(1, 5'd11, $urandom, 0, 1);
    check_model();
    chk("fl_pre_busy", o_busy, 1'b1);
    advance();
    drive(0, '0, $urandom, 1, 0);
    check_model();
    chk("fl_valid", o_wb_valid, 1'b0);
    chk("fl_busy", o_busy, 1'b0);
    chk("fl_ready", o_issue_ready, 1'b1);
    advance();

`ifdef SHIFT_WB_BYPASS_EN
    drive(1, 5'd7, '0, 1, 0);
    step();
    r = $urandom;
    drive(0, '0, r, 1, 0);
    check_model();
    chk("byp_n1_valid", o_wb_valid, 1'b1);
    chk("byp_n1_rd", o_wb_rd, 5'd7);
    chk("byp_n1_data", o_wb_data, r);
    advance();
    check_model();
    chk("byp_n2_valid", o_wb_valid, 1'b0);
    chk("byp_n2_busy", o_busy, 1'b0);
    advance();
`else
    r = $urandom;
    drive(0, '0, r, 1, 0);
    step();
`endif

    // randomized traffic with occasional flushes and mid-run resets
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 373 == 200) do_reset();
      drive($urandom_range(0, 9) < 6, ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom),
            $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
